// File: rtl/counter_bank_pkg.sv
// Shared types and the per-channel step rule for the counter bank.
// The step rule is evaluated in CalcWidth+1 bits so a carry past the bound is never lost.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int CalcWidth = 32;

  // Returns {event, count}. Callers gate up/down with their enable before calling.
  function automatic logic [CalcWidth:0] next_count(
    input logic [CalcWidth-1:0] count,
    input logic [CalcWidth-1:0] step,
    input logic                 up,
    input logic                 down,
    input mode_e                mode,
    input logic [CalcWidth-1:0] max
  );
    logic [CalcWidth:0] sum;
    logic [CalcWidth:0] span;
    span = {1'b0, max} + 1'b1;
    if (up && !down) begin
      sum = {1'b0, count} + {1'b0, step};
      if (sum > {1'b0, max}) begin
        if (mode == MODE_WRAP) return {1'b1, CalcWidth'(sum - span)};
        return {1'b1, max};
      end
      return {1'b0, sum[CalcWidth-1:0]};
    end
    if (down && !up) begin
      if (count < step) begin
        if (mode == MODE_WRAP) return {1'b1, CalcWidth'({1'b0, count} + span - {1'b0, step})};
        return {1'b1, {CalcWidth{1'b0}}};
      end
      return {1'b0, count - step};
    end
    return {1'b0, count};
  endfunction

endpackage

// File: rtl/counter_bank_if.sv
// Bus bundle for counter_bank; COUNTER_BANK_MATCH_EN adds the match-flag signals.
interface counter_bank_if
  import counter_pkg::*;
#(
  parameter int Channels  = 4,
  parameter int Width     = 8,
  parameter int StepWidth = 2
) ();

  logic [Channels-1:0]            en_i;
  logic [Channels-1:0]            up_i;
  logic [Channels-1:0]            down_i;
  logic [StepWidth-1:0]           step_i;
  mode_e                          mode_i;
  logic [Channels-1:0]            load_i;
  logic [Width-1:0]               load_val_i;
  logic [Channels-1:0][Width-1:0] count_o;
  logic [Channels-1:0][Width-1:0] next_count_o;
  logic [Channels-1:0]            at_max_o;
  logic [Channels-1:0]            at_min_o;
  logic [Channels-1:0]            event_o;
`ifdef COUNTER_BANK_MATCH_EN
  logic [Width-1:0]               match_val_i;
  logic                           match_clr_i;
  logic [Channels-1:0]            match_o;
`endif

  modport master (
    output en_i, up_i, down_i, step_i, mode_i, load_i, load_val_i,
    input  count_o, next_count_o, at_max_o, at_min_o, event_o
`ifdef COUNTER_BANK_MATCH_EN
    , output match_val_i, match_clr_i
    , input  match_o
`endif
  );

  modport slave (
    input  en_i, up_i, down_i, step_i, mode_i, load_i, load_val_i,
    output count_o, next_count_o, at_max_o, at_min_o, event_o
`ifdef COUNTER_BANK_MATCH_EN
    , input  match_val_i, match_clr_i
    , output match_o
`endif
  );

endinterface

// File: rtl/counter_bank_chan.sv
// One counter channel: count register, boundary event and optional sticky match flag
// (present when COUNTER_BANK_MATCH_EN is defined).
module counter_chan
  import counter_pkg::*;
#(
  parameter int               Width     = 8,
  parameter logic [Width-1:0] MaxVal    = '1,
  parameter logic [Width-1:0] ResetVal  = '0,
  parameter int               StepWidth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 up_i,
  input  logic                 down_i,
  input  logic [StepWidth-1:0] step_i,
  input  mode_e                mode_i,
  input  logic                 load_i,
  input  logic [Width-1:0]     load_val_i,
`ifdef COUNTER_BANK_MATCH_EN
  input  logic [Width-1:0]     match_val_i,
  input  logic                 match_clr_i,
  output logic                 match_o,
`endif
  output logic [Width-1:0]     count_o,
  output logic [Width-1:0]     next_count_o,
  output logic                 at_max_o,
  output logic                 at_min_o,
  output logic                 event_o
);

  logic [Width-1:0]   count_q, count_d;
  logic               evt_q, evt_d;
  logic [CalcWidth:0] step_res;
  logic               unused_res;

  always_comb begin
    step_res = next_count(CalcWidth'(count_q), CalcWidth'(step_i), en_i & up_i,
                          en_i & down_i, mode_i, CalcWidth'(MaxVal));
    count_d  = step_res[Width-1:0];
    evt_d    = step_res[CalcWidth];
    if (load_i) begin
      count_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
      evt_d   = 1'b0;
    end
  end

  assign unused_res = ^step_res[CalcWidth-1:Width];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= ResetVal;
      evt_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      evt_q   <= evt_d;
    end
  end

  assign count_o      = count_q;
  assign next_count_o = rst_i ? ResetVal : count_d;
  assign at_max_o     = (count_q == MaxVal);
  assign at_min_o     = (count_q == '0);
  assign event_o      = evt_q;

`ifdef COUNTER_BANK_MATCH_EN
  logic match_q, match_d;

  // Set only on the transition into equality so a held match can still be cleared.
  always_comb begin
    match_d = match_q;
    if (match_clr_i) match_d = 1'b0;
    if ((count_d == match_val_i) && (count_q != match_val_i)) match_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) match_q <= 1'b0;
    else       match_q <= match_d;
  end

  assign match_o = match_q;
`endif

endmodule

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with wrap/saturate, load and boundary events.
// Optional match flags are built when COUNTER_BANK_MATCH_EN is defined.
module counter_bank
  import counter_pkg::*;
#(
  parameter int               Channels  = 4,
  parameter int               Width     = 8,
  parameter logic [Width-1:0] MaxVal    = '1,
  parameter logic [Width-1:0] ResetVal  = '0,
  parameter int               StepWidth = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  counter_bank_if.slave bus
);

  if (ResetVal > MaxVal) begin : g_bad_reset_val
    $error("counter_bank: ResetVal exceeds MaxVal");
  end
  if (((1 << StepWidth) - 1) > int'(MaxVal)) begin : g_bad_step_width
    $error("counter_bank: largest step exceeds MaxVal");
  end

  for (genvar gi = 0; gi < Channels; gi++) begin : g_chan
    counter_chan #(
      .Width     (Width),
      .MaxVal    (MaxVal),
      .ResetVal  (ResetVal),
      .StepWidth (StepWidth)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_i         (bus.en_i[gi]),
      .up_i         (bus.up_i[gi]),
      .down_i       (bus.down_i[gi]),
      .step_i       (bus.step_i),
      .mode_i       (bus.mode_i),
      .load_i       (bus.load_i[gi]),
      .load_val_i   (bus.load_val_i),
`ifdef COUNTER_BANK_MATCH_EN
      .match_val_i  (bus.match_val_i),
      .match_clr_i  (bus.match_clr_i),
      .match_o      (bus.match_o[gi]),
`endif
      .count_o      (bus.count_o[gi]),
      .next_count_o (bus.next_count_o[gi]),
      .at_max_o     (bus.at_max_o[gi]),
      .at_min_o     (bus.at_min_o[gi]),
      .event_o      (bus.event_o[gi])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// Directed and random stimulus for counter_bank (2 channels, Width 4, MaxVal 9),
// checked against a modular-arithmetic reference model.
module tb_counter_bank;
  import counter_pkg::*;

  localparam int Ch  = 2;
  localparam int Mx  = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   mdl_cnt[Ch];
  bit   mdl_evt[Ch];

  always #5 clk = ~clk;

  counter_bank_if #(.Channels(Ch), .Width(4), .StepWidth(2)) bus ();

  counter_bank #(
    .Channels(Ch), .Width(4), .MaxVal(4'd9), .ResetVal(4'd0), .StepWidth(2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(logic [1:0] en, logic [1:0] up, logic [1:0] dn, logic [1:0] ld,
                        logic [1:0] step, logic sat, logic [3:0] lval);
    bus.en_i       = en;
    bus.up_i       = up;
    bus.down_i     = dn;
    bus.load_i     = ld;
    bus.step_i     = step;
    bus.mode_i     = sat ? MODE_SAT : MODE_WRAP;
    bus.load_val_i = lval;
  endtask

  function automatic void model_step(int c, output int nc, output bit ne);
    int cur;
    int st;
    cur = mdl_cnt[c];
    st  = int'(bus.step_i);
    nc  = cur;
    ne  = 1'b0;
    if (bus.load_i[c]) begin
      nc = (int'(bus.load_val_i) > Mx) ? Mx : int'(bus.load_val_i);
    end else if (bus.en_i[c] && bus.up_i[c] && !bus.down_i[c]) begin
      ne = (cur + st) > Mx;
      if (bus.mode_i == MODE_WRAP) nc = (cur + st) % (Mx + 1);
      else                         nc = ne ? Mx : cur + st;
    end else if (bus.en_i[c] && bus.down_i[c] && !bus.up_i[c]) begin
      ne = cur < st;
      if (bus.mode_i == MODE_WRAP) nc = (cur - st + Mx + 1) % (Mx + 1);
      else                         nc = ne ? 0 : cur - st;
    end
  endfunction

  task automatic check_outputs(string tag);
    for (int c = 0; c < Ch; c++) begin
      check($sformatf("%s cnt%0d", tag, c), 32'(bus.count_o[c]), mdl_cnt[c]);
      check($sformatf("%s evt%0d", tag, c), 32'(bus.event_o[c]), 32'(mdl_evt[c]));
      check($sformatf("%s max%0d", tag, c), 32'(bus.at_max_o[c]), 32'(mdl_cnt[c] == Mx));
      check($sformatf("%s min%0d", tag, c), 32'(bus.at_min_o[c]), 32'(mdl_cnt[c] == 0));
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(string tag);
    int nc[Ch];
    bit ne[Ch];
    #1;
    for (int c = 0; c < Ch; c++) begin
      model_step(c, nc[c], ne[c]);
      check($sformatf("%s nxt%0d", tag, c), 32'(bus.next_count_o[c]), nc[c]);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < Ch; c++) begin
      mdl_cnt[c] = nc[c];
      mdl_evt[c] = ne[c];
    end
    check_outputs(tag);
    $display("%-8s en=%b up=%b dn=%b ld=%b step=%0d mode=%0d lval=%0d -> cnt=%0d,%0d evt=%b",
             tag, bus.en_i, bus.up_i, bus.down_i, bus.load_i, bus.step_i, bus.mode_i,
             bus.load_val_i, bus.count_o[0], bus.count_o[1], bus.event_o);
    @(negedge clk);
  endtask

  initial begin
`ifdef COUNTER_BANK_MATCH_EN
    bus.match_val_i = '0;
    bus.match_clr_i = 1'b0;
`endif
    set_in(2'b11, 2'b11, 2'b00, 2'b00, 2'd1, 1'b0, 4'd0);
    for (int c = 0; c < Ch; c++) begin
      mdl_cnt[c] = 0;
      mdl_evt[c] = 1'b0;
    end

    // Held in reset with requests active: nothing moves.
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < Ch; c++)
      check($sformatf("rst nxt%0d", c), 32'(bus.next_count_o[c]), 0);
    check_outputs("rst");
    $display("reset    cnt=%0d,%0d evt=%b", bus.count_o[0], bus.count_o[1], bus.event_o);
    set_in(2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 4'd0);
    rst = 1'b0;

    // Reset mid-count: asserted between edges, count drops immediately.
    set_in(2'b00, 2'b00, 2'b00, 2'b01, 2'd0, 1'b0, 4'd5);
    cycle("ld5");
    set_in(2'b01, 2'b01, 2'b00, 2'b00, 2'd1, 1'b0, 4'd0);
    rst = 1'b1;
    #1;
    mdl_cnt[0] = 0;
    mdl_evt[0] = 1'b0;
    check("midrst nxt0", 32'(bus.next_count_o[0]), 0);
    check_outputs("midrst");
    $display("midrst   cnt=%0d,%0d evt=%b", bus.count_o[0], bus.count_o[1], bus.event_o);
    @(negedge clk);
    rst = 1'b0;
    cycle("postrst");

    // WRAP up on ch0 while ch1 idles.
    set_in(2'b00, 2'b00, 2'b00, 2'b01, 2'd0, 1'b0, 4'd8);
    cycle("ld8");
    set_in(2'b01, 2'b01, 2'b00, 2'b00, 2'd3, 1'b0, 4'd0);
    cycle("wrapup");
    set_in(2'b00, 2'b00, 2'b00, 2'b00, 2'd3, 1'b0, 4'd0);
    cycle("idle");

    // WRAP down on ch1, then up&down together holds.
    set_in(2'b00, 2'b00, 2'b00, 2'b10, 2'd0, 1'b0, 4'd1);
    cycle("ld1");
    set_in(2'b10, 2'b00, 2'b10, 2'b00, 2'd2, 1'b0, 4'd0);
    cycle("wrapdn");
    set_in(2'b11, 2'b11, 2'b11, 2'b00, 2'd2, 1'b0, 4'd0);
    cycle("updn");

    // SAT: clip twice at the top, exact reach, clip at the bottom.
    set_in(2'b00, 2'b00, 2'b00, 2'b01, 2'd0, 1'b1, 4'd7);
    cycle("ld7");
    set_in(2'b01, 2'b01, 2'b00, 2'b00, 2'd3, 1'b1, 4'd0);
    cycle("satup1");
    cycle("satup2");
    set_in(2'b00, 2'b00, 2'b00, 2'b01, 2'd0, 1'b1, 4'd6);
    cycle("ld6");
    set_in(2'b01, 2'b01, 2'b00, 2'b00, 2'd3, 1'b1, 4'd0);
    cycle("satexact");
    set_in(2'b00, 2'b00, 2'b00, 2'b01, 2'd0, 1'b1, 4'd1);
    cycle("ld1b");
    set_in(2'b01, 2'b00, 2'b01, 2'b00, 2'd3, 1'b1, 4'd0);
    cycle("satdn");

    // Load clamp with en low, load beating up, step zero holding.
    set_in(2'b00, 2'b00, 2'b00, 2'b11, 2'd0, 1'b0, 4'd12);
    cycle("ld12");
    set_in(2'b01, 2'b01, 2'b00, 2'b01, 2'd1, 1'b0, 4'd2);
    cycle("ldwins");
    set_in(2'b11, 2'b11, 2'b00, 2'b00, 2'd0, 1'b0, 4'd0);
    cycle("step0");

    for (int i = 0; i < 80; i++) begin
      set_in(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      cycle($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
